// File: rtl/shift_arb_pkg.sv
// Shared types for the shifter arbiter: FSM encoding, owner IDs and shift direction.
package shift_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_ALIGN = 1'b0,
    OWN_NORM  = 1'b1
  } owner_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Alignment shifts right, normalization shifts left.
  function automatic logic dir_of(input owner_e owner);
    return (owner == OWN_NORM) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/shift_arbiter_ctrl_if.sv
// Requester and shifter-side bundle for shift_arbiter_ctrl.
// Handshake: a requester raises req with value/data stable and holds them until it sees
// its one-cycle gnt; done pulses exactly one cycle later with result_o valid in that cycle.
interface shift_arbiter_ctrl_if #(
  parameter int SW = 32,
  parameter int EW = 8
);
  logic          align_req_i;
  logic [EW-1:0] align_value_i;
  logic [SW-1:0] align_data_i;
  logic          align_gnt_o;
  logic          align_done_o;

  logic          norm_req_i;
  logic [EW-1:0] norm_value_i;
  logic [SW-1:0] norm_data_i;
  logic          norm_gnt_o;
  logic          norm_done_o;

  logic          sh_load_o;
  logic [EW-1:0] sh_value_o;
  logic [SW-1:0] sh_data_o;
  logic          sh_left_right_o;
  logic [SW-1:0] sh_result_i;

  logic [SW-1:0] result_o;
  logic          busy_o;

  modport slave (
    input  align_req_i, align_value_i, align_data_i,
    input  norm_req_i, norm_value_i, norm_data_i,
    input  sh_result_i,
    output align_gnt_o, align_done_o, norm_gnt_o, norm_done_o,
    output sh_load_o, sh_value_o, sh_data_o, sh_left_right_o,
    output result_o, busy_o
  );

  modport master (
    output align_req_i, align_value_i, align_data_i,
    output norm_req_i, norm_value_i, norm_data_i,
    output sh_result_i,
    input  align_gnt_o, align_done_o, norm_gnt_o, norm_done_o,
    input  sh_load_o, sh_value_o, sh_data_o, sh_left_right_o,
    input  result_o, busy_o
  );
endinterface

// File: rtl/arb2_rr.sv
// Two-input arbiter (a = align, b = norm). SHIFT_ARB_RR_EN selects round robin;
// otherwise input a has fixed priority.
module arb2_rr (
  input  logic clk,
  input  logic rst,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic advance_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

`ifdef SHIFT_ARB_RR_EN
  logic prio_b_q, prio_b_d;

  // Pointer moves to the requester that did not win, so a held loser goes next.
  always_comb begin
    prio_b_d = prio_b_q;
    if (advance_i && gnt_a_o) begin
      prio_b_d = 1'b1;
    end else if (advance_i && gnt_b_o) begin
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

  assign gnt_a_o = req_a_i & (~req_b_i | ~prio_b_q);
  assign gnt_b_o = req_b_i & (~req_a_i |  prio_b_q);
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance_i};

  assign gnt_a_o = req_a_i;
  assign gnt_b_o = req_b_i & ~req_a_i;
`endif

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Shares one registered shifter between the alignment (right) and normalization (left)
// requesters. Arbitration policy is chosen by the SHIFT_ARB_RR_EN macro inside arb2_rr.
module shift_arbiter_ctrl
  import shift_arb_pkg::*;
#(
  parameter int SW = 32,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_arbiter_ctrl_if.slave  arb_if,
  output state_e               state_dbg_o
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          dir_q, dir_d;
  logic [EW-1:0] value_q, value_d;
  logic [SW-1:0] data_q, data_d;
  logic [SW-1:0] result_q, result_d;

  logic gnt_align, gnt_norm;

  arb2_rr u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a_i   (arb_if.align_req_i),
    .req_b_i   (arb_if.norm_req_i),
    .advance_i (state_q == ST_IDLE),
    .gnt_a_o   (gnt_align),
    .gnt_b_o   (gnt_norm)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    dir_d    = dir_q;
    value_d  = value_q;
    data_d   = data_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_align || gnt_norm) begin
          state_d = ST_LOAD;
          owner_d = gnt_norm ? OWN_NORM : OWN_ALIGN;
          dir_d   = dir_of(owner_d);
          value_d = gnt_norm ? arb_if.norm_value_i : arb_if.align_value_i;
          data_d  = gnt_norm ? arb_if.norm_data_i  : arb_if.align_data_i;
        end
      end
      ST_LOAD: begin
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        state_d  = ST_IDLE;
        result_d = arb_if.sh_result_i;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_ALIGN;
      dir_q    <= DIR_RIGHT;
      value_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      value_q  <= value_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // done is masked by rst so a reset landing in RESULT aborts the pulse too.
  assign arb_if.align_gnt_o  = (state_q == ST_LOAD) && (owner_q == OWN_ALIGN);
  assign arb_if.norm_gnt_o   = (state_q == ST_LOAD) && (owner_q == OWN_NORM);
  assign arb_if.align_done_o = (state_q == ST_RESULT) && (owner_q == OWN_ALIGN) && !rst;
  assign arb_if.norm_done_o  = (state_q == ST_RESULT) && (owner_q == OWN_NORM) && !rst;

  assign arb_if.sh_load_o       = (state_q == ST_LOAD);
  assign arb_if.sh_value_o      = value_q;
  assign arb_if.sh_data_o       = data_q;
  assign arb_if.sh_left_right_o = dir_q;

  assign arb_if.result_o = (state_q == ST_RESULT) ? arb_if.sh_result_i : result_q;
  assign arb_if.busy_o   = (state_q != ST_IDLE);
  assign state_dbg_o     = state_q;

endmodule
